// File: rtl/half_mult_seq.sv
// Sequential binary16 multiplier: shift-add significand loop,
// RNE rounding, flush-to-zero on subnormal inputs and outputs.
module half_mult_seq #(
  parameter int N = 16,
  parameter int EXP_BIAS = 15,
  parameter logic [15:0] QNAN_PAT = 16'h7E00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  state_t state;

  logic [3:0]  cnt;
  logic [21:0] acc;
  logic [21:0] mc;
  logic [10:0] mb;
  logic signed [6:0] e_r;
  logic        sgn;

  logic [4:0] ea, eb;
  logic       sgn_ab;
  logic       a_nan, b_nan, a_snan, b_snan;
  logic       a_inf, b_inf, a_zero, b_zero;
  logic       any_nan, any_inf, any_zero;
  logic       c_nan, c_ivz, c_inf, c_zero;
  logic       spec;
  logic [15:0] sres;
  logic [3:0]  sflg;

  assign ea     = a[14:10];
  assign eb     = b[14:10];
  assign sgn_ab = a[15] ^ b[15];

  assign a_nan  = (ea == 5'h1f) && (a[9:0] != 10'd0);
  assign b_nan  = (eb == 5'h1f) && (b[9:0] != 10'd0);
  assign a_snan = a_nan && !a[9];
  assign b_snan = b_nan && !b[9];
  assign a_inf  = (ea == 5'h1f) && (a[9:0] == 10'd0);
  assign b_inf  = (eb == 5'h1f) && (b[9:0] == 10'd0);
  // exponent zero covers subnormals, which flush to zero
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);

  assign any_nan  = a_nan | b_nan;
  assign any_inf  = a_inf | b_inf;
  assign any_zero = a_zero | b_zero;

  assign c_nan  = any_nan;
  assign c_ivz  = !any_nan && any_inf && any_zero;
  assign c_inf  = !any_nan && any_inf && !any_zero;
  assign c_zero = !any_nan && !any_inf && any_zero;

  always_comb begin
    spec = 1'b1;
    sres = 16'h0000;
    sflg = 4'b0000;
    unique case (1'b1)
      c_nan: begin
        sres = QNAN_PAT;
        sflg = {a_snan | b_snan, 3'b000};
      end
      c_ivz: begin
        sres = QNAN_PAT;
        sflg = 4'b1000;
      end
      c_inf:  sres = {sgn_ab, 15'h7C00};
      c_zero: sres = {sgn_ab, 15'h0000};
      default: spec = 1'b0;
    endcase
  end

  logic        hi, g, st, inc;
  logic [9:0]  fr;
  logic [10:0] fr11;
  logic signed [6:0] e1, e2;
  logic [15:0] nres;
  logic [3:0]  nflg;

  always_comb begin
    hi   = acc[21];
    fr   = hi ? acc[20:11] : acc[19:10];
    g    = hi ? acc[10] : acc[9];
    st   = hi ? |acc[9:0] : |acc[8:0];
    e1   = e_r + $signed({6'b0, hi});
    inc  = g & (st | fr[0]);
    fr11 = {1'b0, fr} + {10'b0, inc};
    e2   = e1 + $signed({6'b0, fr11[10]});
    nres = {sgn, e2[4:0], fr11[10] ? 10'd0 : fr11[9:0]};
    nflg = {3'b000, g | st};
    if (e2 >= 7'sd31) begin
      nres = {sgn, 15'h7C00};
      nflg = 4'b0101;
    end else if (e2 <= 7'sd0) begin
      nres = {sgn, 15'h0000};
      nflg = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0;
      acc       <= '0;
      mc        <= '0;
      mb        <= '0;
      cnt       <= '0;
      e_r       <= '0;
      sgn       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (spec) begin
              result    <= sres;
              flags     <= sflg;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc   <= '0;
              mc    <= {11'b0, 1'b1, a[9:0]};
              mb    <= {1'b1, b[9:0]};
              cnt   <= '0;
              e_r   <= $signed({2'b0, ea} + {2'b0, eb}
                       - 7'(EXP_BIAS));
              sgn   <= sgn_ab;
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (mb[0]) acc <= acc + mc;
          mc  <= mc << 1;
          mb  <= mb >> 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd10) state <= NORM;
        end
        NORM: begin
          result    <= nres;
          flags     <= nflg;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            flags     <= 4'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_half_mult_seq.sv
// Directed and random checks of half_mult_seq against an
// arithmetic binary16 multiply model.
module tb_half_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int nchk  = 0;
  int nfail = 0;

  half_mult_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    nchk++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic bit is_spec(input logic [15:0] x);
    return (x[14:10] == 5'h1f) || (x[14:10] == 5'h00);
  endfunction

  // returns {result, flags}
  function automatic logic [19:0] model(input logic [15:0] x,
                                        input logic [15:0] y);
    int ex, ey, fx, fy, e, s, half, q;
    longint p, rem;
    bit sx, xn, yn, xs, ys, xi, yi, xz, yz;
    logic [15:0] r;
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    fx = int'(x[9:0]);   fy = int'(y[9:0]);
    sx = x[15] ^ y[15];
    xn = (ex == 31) && (fx != 0); yn = (ey == 31) && (fy != 0);
    xs = xn && (fx < 512);        ys = yn && (fy < 512);
    xi = (ex == 31) && (fx == 0); yi = (ey == 31) && (fy == 0);
    xz = (ex == 0);               yz = (ey == 0);
    if (xn || yn) return {16'h7E00, (xs || ys), 3'b000};
    if ((xi || yi) && (xz || yz)) return {16'h7E00, 4'b1000};
    if (xi || yi) return {sx, 15'h7C00, 4'b0000};
    if (xz || yz) return {sx, 15'h0000, 4'b0000};
    p = longint'(1024 + fx) * longint'(1024 + fy);
    e = ex + ey - 15;
    s = (p >= 64'd2097152) ? 11 : 10;
    e += s - 10;
    q = int'(p >> s);
    rem = p - (longint'(q) << s);
    half = 1 << (s - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == 2048) begin q = 1024; e++; end
    if (e >= 31) return {sx, 15'h7C00, 4'b0101};
    if (e <= 0) return {sx, 15'h0000, 4'b0011};
    r = {sx, 5'(e), 10'(q - 1024)};
    return {r, 3'b000, rem != 0};
  endfunction

  task automatic run(input string tag,
                     input logic [15:0] x,
                     input logic [15:0] y,
                     input int hold);
    logic [19:0] m;
    int lat, n;
    bit got;
    m = model(x, y);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); n++;
    end
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk); lat++;
      if (out_valid) got = 1'b1;
      else @(posedge clk);
    end
    chk({tag, " latency"}, 32'(lat),
        (is_spec(x) || is_spec(y)) ? 32'd1 : 32'd13);
    chk({tag, " result"}, 32'(result), 32'(m[19:4]));
    chk({tag, " flags"}, 32'(flags), 32'(m[3:0]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk({tag, " hold res"}, 32'(result), 32'(m[19:4]));
      chk({tag, " hold flg"}, 32'(flags), 32'(m[3:0]));
      chk({tag, " hold ovld"}, 32'(out_valid), 32'd1);
      chk({tag, " hold irdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " idle irdy"}, 32'(in_ready), 32'd1);
    chk({tag, " idle ovld"}, 32'(out_valid), 32'd0);
    chk({tag, " idle flg"}, 32'(flags), 32'd0);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 7) == 0)
      v[14:10] = ($urandom_range(0, 1) == 1) ? 5'h1f : 5'h00;
    else
      v[14:10] = 5'($urandom_range(4, 26));
    return v;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);

    run("1x1", 16'h3C00, 16'h3C00, 0);
    chk("1x1 const", 32'(model(16'h3C00, 16'h3C00)), 32'h3C000);
    run("2x3", 16'h4000, 16'h4200, 0);
    chk("2x3 const", 32'(model(16'h4000, 16'h4200)), 32'h46000);
    run("rnd_dn", 16'h3C01, 16'h3C01, 0);
    chk("rnd_dn const", 32'(model(16'h3C01, 16'h3C01)), 32'h3C021);
    run("ovf", 16'h7BFF, 16'h4000, 0);
    chk("ovf const", 32'(model(16'h7BFF, 16'h4000)), 32'h7C005);
    run("unf", 16'h0400, 16'h0400, 0);
    chk("unf const", 32'(model(16'h0400, 16'h0400)), 32'h00003);
    run("infx0", 16'h7C00, 16'h0000, 0);
    run("snan", 16'h7D00, 16'h3C00, 0);
    chk("snan const", 32'(model(16'h7D00, 16'h3C00)), 32'h7E008);
    run("qnan", 16'h7E01, 16'h3C00, 0);
    run("ninf", 16'hFC00, 16'h4000, 0);
    run("nzero", 16'h8000, 16'h4000, 0);
    run("subn", 16'h0200, 16'hC000, 0);
    run("hold", 16'h4000, 16'h4200, 5);

    @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    run("post rst", 16'h3C00, 16'h3C00, 0);

    for (int i = 0; i < 40; i++)
      run("random", rnd_op(), rnd_op(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
